branch_target_buffer_param: RTL and testbench
=============================================

// Module: branch_target_buffer_param
// PURPOSE
//  Parametrised, tagged, direct-mapped branch target buffer with per-entry 2-bit saturating predictor.
//  Fetch stage does a combinational lookup on the fetch PC. Execute stage writes resolved branch outcomes back.
//  Adds tag check, valid bits, taken/not-taken training, one-cycle flush and saturating hit/lookup perf counters.
// PARAMETERS
//  ADDR_W      32     PC / target width in bits
//  ENTRIES     64     number of entries; power of two, >= 2
//  IDX_W       $clog2(ENTRIES)  localparam; index = pc[IDX_W+1:2]
//  TAG_W       ADDR_W-2-IDX_W   localparam; tag = pc[ADDR_W-1:IDX_W+2]
//  CNT_W       32     width of each perf counter
// PORTS
//  clk             in   1       clock, all state updates on posedge
//  rst_n           in   1       asynchronous active-low reset
//  lookup_en       in   1       fetch-stage lookup request
//  lookup_pc       in   ADDR_W  fetch PC
//  hit             out  1       valid entry with matching tag, gated by lookup_en
//  predict_taken   out  1       hit & counter[1]
//  predict_target  out  ADDR_W  stored target when hit, else 0
//  predict_state   out  2       counter of indexed entry when hit, else 2'b00
//  update_en       in   1       execute-stage resolved-branch writeback
//  update_pc       in   ADDR_W  PC of resolved branch
//  update_taken    in   1       actual branch outcome
//  update_target   in   ADDR_W  actual target (meaningful when taken)
//  flush           in   1       invalidate all entries
//  lookup_count    out  CNT_W   number of cycles with lookup_en=1, saturating
//  hit_count       out  CNT_W   number of cycles with hit=1, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): all valid=0, all counters=2'b01, perf counters=0. Targets/tags need no reset.
//    Lookup outputs are therefore 0 during and immediately after reset.
//  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//  - Lookup: purely combinational, zero latency. Reads state as of the last clock edge.
//    With lookup_en=0, all lookup outputs are 0.
//  - Update on update_en=1, applied at the next posedge:
//    . Hit (valid & tag match) and taken: counter +1 saturating at 11; target <= update_target.
//    . Hit and not taken: counter -1 saturating at 00; target unchanged.
//    . Miss and taken: allocate/replace the entry: valid=1, tag, target, counter=2'b10.
//    . Miss and not taken: no change (no allocation).
//  - Lookup and update to the same index in the same cycle: there is no bypass.
//    Lookup sees the pre-update contents; the update lands at the edge.
//  - Index aliasing: on a miss-taken update, a different PC with the same index overwrites the entry.
//  - Flush: all valid <= 0 at the next edge, and counters <= 01.
//    Flush has priority over a simultaneous update, which is dropped.
//    Perf counters are unaffected by flush.
//  - Perf counters: increment by 1 per qualifying cycle and hold at all-ones; never wrap.
//  - update_pc / lookup_pc bits [1:0] are ignored.
// STRUCTURE
//  - btb_pkg: counter state localparams (SN, WN, WT, ST), ALLOC_STATE=WT, RESET_STATE=WN,
//    and index/tag extract functions parameterised on IDX_W.
//  - Sub-module btb_sat_counter: combinational 2-bit saturating next-state (cur, inc, dec -> nxt).
//  - Storage: valid and counter arrays as flops (async reset/flush).
//    Tag and target arrays as plain regs written on update.
// TESTING
//  1 Reset then lookup 0x0000_0040 -> hit=0, predict_taken=0, target=0, state=00, lookup_count=1.
//  2 Update pc=0x40 taken target=0x100, then lookup 0x40 -> hit=1, taken=1, target=0x100, state=10.
//  3 Three more taken updates to 0x40 -> state 11 (holds at 11).
//    Then 4 not-taken updates -> 10, 01, 00, 00; predict_taken=0 once state<10.
//  4 Alias: ENTRIES=64, update 0x40 taken, lookup 0x140 -> hit=0.
//    Then update 0x140 taken target 0x200 -> lookup 0x40 hit=0, lookup 0x140 hit=1 target 0x200.
//  5 Same-cycle lookup and miss-taken update on 0x80 -> hit=0 that cycle, hit=1 next cycle.
//    Flush together with update on 0x80 -> entry stays invalid.
//  6 Assert rst_n low mid-run with populated entries -> outputs 0 immediately and counts=0.
//    With CNT_W=4, 20 lookup cycles -> lookup_count=4'hF.

Source files
------------

// File: rtl/btb_pkg.sv
// Purpose : shared constants and PC field helpers for the branch target buffer.
// Latency : n/a (package).
// Backpr. : n/a (package).
package btb_pkg;

    // 2-bit predictor encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
    localparam logic [1:0] SN = 2'b00;
    localparam logic [1:0] WN = 2'b01;
    localparam logic [1:0] WT = 2'b10;
    localparam logic [1:0] ST = 2'b11;

    // A freshly allocated entry was just seen taken, so it starts weakly taken.
    localparam logic [1:0] ALLOC_STATE = WT;
    localparam logic [1:0] RESET_STATE = WN;

    // Index field is pc[idx_w+1:2]; word-aligned PCs, so bits [1:0] never matter.
    // Results are returned at full 64-bit width; callers truncate with a size cast.
    function automatic logic [63:0] btb_index(input logic [63:0] pc, input int idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return (pc >> 2) & mask;
    endfunction

    // Tag field is everything above the index.
    function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Purpose : 2-bit saturating counter next-state (inc/dec clamp at 11/00).
// Latency : combinational, zero cycles.
// Backpr. : none; holds the current value when inc==dec.
// Ports   : i_cur current state, i_inc/i_dec step request, o_nxt next state.
module btb_sat_counter
    import btb_pkg::*;
(
    input  logic [1:0] i_cur,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [1:0] o_nxt
);

    always_comb begin
        o_nxt = i_cur;
        if (i_inc && !i_dec) begin
            if (i_cur != ST) o_nxt = i_cur + 2'd1;
        end else if (i_dec && !i_inc) begin
            if (i_cur != SN) o_nxt = i_cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer_param.sv
// Purpose : tagged direct-mapped BTB with 2-bit predictor per entry and perf counters.
// Latency : lookup is combinational (zero cycles); updates/flush land at the next posedge.
// Backpr. : none; lookup and update are accepted every cycle, flush wins over update.
// Ports   : lookup_en/lookup_pc -> hit, predict_taken/target/state (fetch side);
//           update_en/pc/taken/target (execute writeback); flush; lookup_count, hit_count.
module branch_target_buffer_param
    import btb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              hit,
    output logic              predict_taken,
    output logic [ADDR_W-1:0] predict_target,
    output logic [1:0]        predict_state,
    input  logic              update_en,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              flush,
    output logic [CNT_W-1:0]  lookup_count,
    output logic [CNT_W-1:0]  hit_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    // Valid and predictor state need a known value after reset/flush; tag and
    // target are only ever observed behind a set valid bit, so they stay unreset.
    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];

    logic [CNT_W-1:0]   r_lookup_count;
    logic [CNT_W-1:0]   r_hit_count;

    logic [IDX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic               w_lk_hit;
    logic [IDX_W-1:0]   w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_up_hit;
    logic [1:0]         w_ctr_nxt;

    assign w_lk_idx = IDX_W'(btb_index(64'(lookup_pc), IDX_W));
    assign w_lk_tag = TAG_W'(btb_tag(64'(lookup_pc), IDX_W));
    assign w_up_idx = IDX_W'(btb_index(64'(update_pc), IDX_W));
    assign w_up_tag = TAG_W'(btb_tag(64'(update_pc), IDX_W));

    // Lookup reads storage as of the last edge; no bypass from a same-cycle update.
    assign w_lk_hit = lookup_en && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    assign hit            = w_lk_hit;
    assign predict_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    assign predict_target = w_lk_hit ? r_target[w_lk_idx] : '0;
    assign predict_state  = w_lk_hit ? r_ctr[w_lk_idx] : SN;

    // Only one entry is trained per cycle, so a single counter update unit suffices.
    btb_sat_counter u_sat_counter (
        .i_cur (r_ctr[w_up_idx]),
        .i_inc (update_taken),
        .i_dec (!update_taken),
        .o_nxt (w_ctr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= RESET_STATE;
        end else if (flush) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= RESET_STATE;
        end else if (update_en) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= w_ctr_nxt;
            end else if (update_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= ALLOC_STATE;
            end
        end
    end

    // Every taken update writes tag+target: on a hit the tag is unchanged, on a
    // miss this is the allocation (possibly evicting an aliasing PC).
    always_ff @(posedge clk) begin
        if (update_en && update_taken && !flush) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= update_target;
        end
    end

    // Perf counters saturate at all-ones; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lookup_count <= '0;
            r_hit_count    <= '0;
        end else begin
            if (lookup_en && (r_lookup_count != '1)) r_lookup_count <= r_lookup_count + 1'b1;
            if (w_lk_hit && (r_hit_count != '1))     r_hit_count    <= r_hit_count + 1'b1;
        end
    end

    assign lookup_count = r_lookup_count;
    assign hit_count    = r_hit_count;

endmodule

// File: tb/tb_branch_target_buffer_param.sv
module tb_branch_target_buffer_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lookup_en = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        update_en = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        flush = 1'b0;

    logic        a_hit, a_taken, b_hit, b_taken;
    logic [31:0] a_target, b_target;
    logic [1:0]  a_state, b_state;
    logic [31:0] a_lc, a_hc;
    logic [3:0]  b_lc, b_hc;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_target_buffer_param u_dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .hit(a_hit), .predict_taken(a_taken), .predict_target(a_target), .predict_state(a_state),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .flush(flush),
        .lookup_count(a_lc), .hit_count(a_hc)
    );

    branch_target_buffer_param #(.CNT_W(4)) u_dut_c4 (
        .clk(clk), .rst_n(rst_n),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .hit(b_hit), .predict_taken(b_taken), .predict_target(b_target), .predict_state(b_state),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .flush(flush),
        .lookup_count(b_lc), .hit_count(b_hc)
    );

    // ---------------- behavioural model (64 entries, index=(pc/4)%64, tag=pc/256)
    bit          m_v   [64];
    int unsigned m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ctr [64];
    longint unsigned m_lc, m_hc;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[m_idx(pc)] && (m_tag[m_idx(pc)] == int'(pc / 256));
    endfunction

    function automatic longint unsigned sat(input longint unsigned v, input longint unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 1'b0;
            m_ctr[i] = 1;
        end
        m_lc = 0;
        m_hc = 0;
    endtask

    task automatic model_edge();
        int i;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (lookup_en) m_lc++;
        if (lookup_en && m_hit(lookup_pc)) m_hc++;
        if (flush) begin
            for (int k = 0; k < 64; k++) begin
                m_v[k] = 1'b0;
                m_ctr[k] = 1;
            end
        end else if (update_en) begin
            i = m_idx(update_pc);
            if (m_hit(update_pc)) begin
                if (update_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = update_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (update_taken) begin
                m_v[i]   = 1'b1;
                m_tag[i] = int'(update_pc / 256);
                m_tgt[i] = update_target;
                m_ctr[i] = 2;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit h;
        int i;
        h = lookup_en && m_hit(lookup_pc);
        i = m_idx(lookup_pc);
        chk("cyc_hit",    64'(a_hit), 64'(h));
        chk("cyc_taken",  64'(a_taken), 64'(h && m_ctr[i] >= 2));
        chk("cyc_target", 64'(a_target), h ? 64'(m_tgt[i]) : 64'd0);
        chk("cyc_state",  64'(a_state), h ? 64'(m_ctr[i]) : 64'd0);
        chk("cyc_lcount", 64'(a_lc), sat(m_lc, 64'hFFFF_FFFF));
        chk("cyc_hcount", 64'(a_hc), sat(m_hc, 64'hFFFF_FFFF));
        chk("cyc_b_hit",  64'(b_hit), 64'(h));
        chk("cyc_b_lcnt", 64'(b_lc), sat(m_lc, 15));
        chk("cyc_b_hcnt", 64'(b_hc), sat(m_hc, 15));
    endtask

    // Compare on the falling edge, advance the model on the rising edge,
    // and return 1 time unit after it so inputs change away from the edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_upd(input bit en, input logic [31:0] pc, input bit tk, input logic [31:0] tg);
        update_en = en; update_pc = pc; update_taken = tk; update_target = tg;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int exp_st [4];
        int exp_tk [4];
        exp_st = '{2, 1, 0, 0};
        exp_tk = '{1, 0, 0, 0};

        model_reset();
        repeat (3) step();
        rst_n = 1'b1;

        // Reset-state lookup
        lookup_en = 1'b1; lookup_pc = 32'h0000_0040;
        #1;
        chk("rst_hit", 64'(a_hit), 0);
        chk("rst_taken", 64'(a_taken), 0);
        chk("rst_target", 64'(a_target), 0);
        chk("rst_state", 64'(a_state), 0);
        step();
        chk("rst_lcount", 64'(a_lc), 1);

        // First allocation
        lookup_en = 1'b0;
        set_upd(1, 32'h40, 1, 32'h100);
        step();
        set_upd(0, 0, 0, 0);
        lookup_en = 1'b1; lookup_pc = 32'h40;
        #1;
        chk("alloc_hit", 64'(a_hit), 1);
        chk("alloc_taken", 64'(a_taken), 1);
        chk("alloc_target", 64'(a_target), 64'h100);
        chk("alloc_state", 64'(a_state), 2);
        step();

        // Train up to saturation, then down
        set_upd(1, 32'h40, 1, 32'h100);
        repeat (3) step();
        chk("sat_hi_state", 64'(a_state), 3);
        set_upd(1, 32'h40, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("dec_state", 64'(a_state), 64'(exp_st[k]));
            chk("dec_taken", 64'(a_taken), 64'(exp_tk[k]));
        end

        // Index aliasing 0x40 vs 0x140
        set_upd(1, 32'h40, 1, 32'h100);
        step();
        set_upd(0, 0, 0, 0);
        lookup_pc = 32'h140;
        #1;
        chk("alias_miss", 64'(a_hit), 0);
        step();
        set_upd(1, 32'h140, 1, 32'h200);
        step();
        set_upd(0, 0, 0, 0);
        lookup_pc = 32'h40;
        #1;
        chk("alias_old_evicted", 64'(a_hit), 0);
        step();
        lookup_pc = 32'h140;
        #1;
        chk("alias_new_hit", 64'(a_hit), 1);
        chk("alias_new_target", 64'(a_target), 64'h200);
        step();

        // Same-cycle lookup + allocating update: no bypass
        lookup_pc = 32'h80;
        set_upd(1, 32'h80, 1, 32'h300);
        #1;
        chk("nobypass_hit", 64'(a_hit), 0);
        step();
        set_upd(0, 0, 0, 0);
        chk("nobypass_next_hit", 64'(a_hit), 1);
        // Flush beats update
        flush = 1'b1;
        set_upd(1, 32'h80, 1, 32'h300);
        step();
        flush = 1'b0;
        set_upd(0, 0, 0, 0);
        #1;
        chk("flush_hit", 64'(a_hit), 0);
        step();

        // Asynchronous reset with populated entries
        set_upd(1, 32'h40, 1, 32'h500);
        step();
        set_upd(0, 0, 0, 0);
        lookup_pc = 32'h40;
        #1;
        chk("pre_areset_hit", 64'(a_hit), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset_hit", 64'(a_hit), 0);
        chk("areset_target", 64'(a_target), 0);
        chk("areset_lcount", 64'(a_lc), 0);
        chk("areset_hcount", 64'(a_hc), 0);
        lookup_en = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // 4-bit counter saturation
        lookup_en = 1'b1;
        repeat (20) step();
        chk("c4_lcount_sat", 64'(b_lc), 64'hF);
        chk("c32_lcount", 64'(a_lc), 20);

        // Randomised traffic over a small PC space so hits and aliasing are common
        for (int n = 0; n < 3000; n++) begin
            lookup_en = ($urandom_range(0, 9) < 8);
            lookup_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            set_upd($urandom_range(0, 1) == 1,
                    ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3),
                    $urandom_range(0, 2) != 0, $urandom);
            flush = ($urandom_range(0, 59) == 0);
            step();
        end
        lookup_en = 1'b0;
        set_upd(0, 0, 0, 0);
        flush = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
